// File: rtl/fila_amostras_mc.sv
// Per-channel PCM FIFOs that emit interleaved sets ch0..chN-1; an accepted error flushes all samples.
// Write-to-output latency 1 cycle; valid/ready on both sides. `FILA_AMOSTRAS_SATURACAO_EN adds input saturation.

module fila_amostras_mc_fifo #(
  parameter int LARG = 16,
  parameter int PROF = 4
) (
  input  logic            clk,
  input  logic            limpa_i,
  input  logic            push_i,
  input  logic [LARG-1:0] dado_i,
  input  logic            pop_i,
  output logic [LARG-1:0] cabeca_o,
  output logic            cheio_o,
  output logic            vazio_o
);
  localparam int AW = $clog2(PROF);

  logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LARG-1:0] mem_q [PROF];
  logic            escreve, le;

  assign cheio_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign vazio_o  = (wr_q == rd_q);
  assign cabeca_o = mem_q[rd_q[AW-1:0]];
  assign escreve  = push_i && !cheio_o && !limpa_i;
  assign le       = pop_i && !vazio_o && !limpa_i;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (limpa_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (escreve) wr_d = wr_q + (AW+1)'(1);
      if (le)      rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    wr_q <= wr_d;
    rd_q <= rd_d;
  end

  always_ff @(posedge clk) begin
    if (escreve) mem_q[wr_q[AW-1:0]] <= dado_i;
  end
endmodule

module fila_amostras_mc #(
  parameter int NUM_CANAIS   = 2,
  parameter int LARG_AMOSTRA = 16,
  parameter int PROFUNDIDADE = 4,
  parameter int LARG_ERRO    = 8,
  localparam int LC = (NUM_CANAIS > 1) ? $clog2(NUM_CANAIS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    amostra_in_valid,
  output logic                    amostra_in_ready,
  input  logic [LC-1:0]           amostra_in_canal,
  input  logic [LARG_AMOSTRA-1:0] amostra_in_dado,
`ifdef FILA_AMOSTRAS_SATURACAO_EN
  input  logic [LARG_AMOSTRA+1:0] amostra_in_larga,
  output logic [15:0]             contagem_saturacao,
`endif
  output logic                    amostra_out_valid,
  input  logic                    amostra_out_ready,
  output logic [LC-1:0]           amostra_out_canal,
  output logic [LARG_AMOSTRA-1:0] amostra_out_dado,
  output logic                    amostra_out_fim,
  input  logic                    erro_in_valid,
  output logic                    erro_in_ready,
  input  logic [LARG_ERRO-1:0]    erro_in_codigo,
  output logic                    erro_out_valid,
  input  logic                    erro_out_ready,
  output logic [LARG_ERRO-1:0]    erro_out_codigo,
  output logic [NUM_CANAIS-1:0]   cheio
);
  typedef enum logic {OCIOSO, EMITINDO} estado_t;

  estado_t                 estado_q, estado_d;
  logic [LC-1:0]           canal_saida_q, canal_saida_d;
  logic                    erro_out_valid_q, erro_out_valid_d;
  logic [LARG_ERRO-1:0]    erro_out_codigo_q, erro_out_codigo_d;
  logic [LARG_AMOSTRA-1:0] cabeca [NUM_CANAIS];
  logic [NUM_CANAIS-1:0]   vazio;
  logic [LARG_AMOSTRA-1:0] dado_wr, dado_saida;
  logic                    canal_in_ok, cheio_sel, erro_aceito, wr_ok, pop_ok, ultimo, limpa;

  assign canal_in_ok = 32'(amostra_in_canal) < NUM_CANAIS;

  always_comb begin
    cheio_sel  = 1'b0;
    dado_saida = '0;
    for (int c = 0; c < NUM_CANAIS; c++) begin
      if (amostra_in_canal == LC'(c)) cheio_sel  = cheio[c];
      if (canal_saida_q == LC'(c))    dado_saida = cabeca[c];
    end
  end

  assign erro_in_ready    = !erro_out_valid_q || erro_out_ready;
  assign erro_aceito      = erro_in_valid && erro_in_ready;
  assign limpa            = reset || erro_aceito;
  assign amostra_in_ready = !cheio_sel && !erro_in_valid;
  assign wr_ok            = amostra_in_valid && amostra_in_ready && canal_in_ok && !erro_aceito;

  // Once a set has started every channel is known to hold its sample, so EMITINDO needs no check.
  assign ultimo            = (canal_saida_q == LC'(NUM_CANAIS-1));
  assign amostra_out_valid = !erro_in_valid && ((estado_q == EMITINDO) || (vazio == '0));
  assign amostra_out_canal = canal_saida_q;
  assign amostra_out_dado  = dado_saida;
  assign amostra_out_fim   = ultimo;
  assign pop_ok            = amostra_out_valid && amostra_out_ready && !erro_aceito;

  assign erro_out_valid  = erro_out_valid_q;
  assign erro_out_codigo = erro_out_codigo_q;

`ifdef FILA_AMOSTRAS_SATURACAO_EN
  logic        satura;
  logic [15:0] contagem_q, contagem_d;

  // Top three bits equal means the value already fits in LARG_AMOSTRA signed bits.
  assign satura = !((amostra_in_larga[LARG_AMOSTRA+1] == amostra_in_larga[LARG_AMOSTRA]) &&
                    (amostra_in_larga[LARG_AMOSTRA] == amostra_in_larga[LARG_AMOSTRA-1]));

  always_comb begin
    dado_wr = amostra_in_larga[LARG_AMOSTRA-1:0];
    if (satura)
      dado_wr = amostra_in_larga[LARG_AMOSTRA+1] ? {1'b1, {(LARG_AMOSTRA-1){1'b0}}}
                                                 : {1'b0, {(LARG_AMOSTRA-1){1'b1}}};
  end

  always_comb begin
    contagem_d = contagem_q;
    if (erro_aceito)
      contagem_d = '0;
    else if (wr_ok && satura && (contagem_q != 16'hFFFF))
      contagem_d = contagem_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) contagem_q <= '0;
    else       contagem_q <= contagem_d;
  end

  assign contagem_saturacao = contagem_q;
`else
  assign dado_wr = amostra_in_dado;
`endif

  for (genvar g = 0; g < NUM_CANAIS; g++) begin : g_canal
    fila_amostras_mc_fifo #(
      .LARG (LARG_AMOSTRA),
      .PROF (PROFUNDIDADE)
    ) u_fifo (
      .clk      (clk),
      .limpa_i  (limpa),
      .push_i   (wr_ok && (amostra_in_canal == LC'(g))),
      .dado_i   (dado_wr),
      .pop_i    (pop_ok && (canal_saida_q == LC'(g))),
      .cabeca_o (cabeca[g]),
      .cheio_o  (cheio[g]),
      .vazio_o  (vazio[g])
    );
  end

  always_comb begin
    estado_d      = estado_q;
    canal_saida_d = canal_saida_q;
    if (erro_aceito) begin
      estado_d      = OCIOSO;
      canal_saida_d = '0;
    end else if (pop_ok) begin
      if (ultimo) begin
        estado_d      = OCIOSO;
        canal_saida_d = '0;
      end else begin
        estado_d      = EMITINDO;
        canal_saida_d = canal_saida_q + LC'(1);
      end
    end
  end

  always_comb begin
    erro_out_valid_d  = erro_out_valid_q;
    erro_out_codigo_d = erro_out_codigo_q;
    if (erro_aceito) begin
      erro_out_valid_d  = 1'b1;
      erro_out_codigo_d = erro_in_codigo;
    end else if (erro_out_ready) begin
      erro_out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q          <= OCIOSO;
      canal_saida_q     <= '0;
      erro_out_valid_q  <= 1'b0;
      erro_out_codigo_q <= '0;
    end else begin
      estado_q          <= estado_d;
      canal_saida_q     <= canal_saida_d;
      erro_out_valid_q  <= erro_out_valid_d;
      erro_out_codigo_q <= erro_out_codigo_d;
    end
  end
endmodule

// File: tb/tb_fila_amostras_mc.sv
// Directed bench for fila_amostras_mc with default parameters (2 channels, 16-bit, depth 4).
module tb_fila_amostras_mc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        amostra_in_valid = 1'b0;
  logic        amostra_in_ready;
  logic [0:0]  amostra_in_canal = '0;
  logic [15:0] amostra_in_dado = '0;
  logic        amostra_out_valid;
  logic        amostra_out_ready = 1'b0;
  logic [0:0]  amostra_out_canal;
  logic [15:0] amostra_out_dado;
  logic        amostra_out_fim;
  logic        erro_in_valid = 1'b0;
  logic        erro_in_ready;
  logic [7:0]  erro_in_codigo = '0;
  logic        erro_out_valid;
  logic        erro_out_ready = 1'b0;
  logic [7:0]  erro_out_codigo;
  logic [1:0]  cheio;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [17:0] saidas [$];

  fila_amostras_mc dut (
    .clk               (clk),
    .reset             (reset),
    .amostra_in_valid  (amostra_in_valid),
    .amostra_in_ready  (amostra_in_ready),
    .amostra_in_canal  (amostra_in_canal),
    .amostra_in_dado   (amostra_in_dado),
    .amostra_out_valid (amostra_out_valid),
    .amostra_out_ready (amostra_out_ready),
    .amostra_out_canal (amostra_out_canal),
    .amostra_out_dado  (amostra_out_dado),
    .amostra_out_fim   (amostra_out_fim),
    .erro_in_valid     (erro_in_valid),
    .erro_in_ready     (erro_in_ready),
    .erro_in_codigo    (erro_in_codigo),
    .erro_out_valid    (erro_out_valid),
    .erro_out_ready    (erro_out_ready),
    .erro_out_codigo   (erro_out_codigo),
    .cheio             (cheio)
  );

  always #5 clk = ~clk;

  // Output handshakes logged as {canal, fim, dado}.
  always @(negedge clk)
    if (!reset && amostra_out_valid && amostra_out_ready)
      saidas.push_back({amostra_out_canal, amostra_out_fim, amostra_out_dado});

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_cmp++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: obtido=0x%0h esperado=0x%0h", tag, obs, esp);
    end
  endtask

  function automatic logic [17:0] le_saida(input int i);
    if (i < saidas.size()) return saidas[i];
    return '1;
  endfunction

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic espera(input int n);
    repeat (n) ciclo();
  endtask

  task automatic escreve(input logic [0:0] c, input logic [15:0] d);
    amostra_in_valid = 1'b1;
    amostra_in_canal = c;
    amostra_in_dado  = d;
    #1;
    verifica($sformatf("wr_ready_c%0d_%0h", c, d), 32'(amostra_in_ready), 32'd1);
    ciclo();
    amostra_in_valid = 1'b0;
  endtask

  task automatic aplica_reset();
    reset             = 1'b1;
    amostra_in_valid  = 1'b0;
    amostra_out_ready = 1'b0;
    erro_in_valid     = 1'b0;
    erro_out_ready    = 1'b0;
    espera(2);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    aplica_reset();
    verifica("rst_out_valid", 32'(amostra_out_valid), 32'd0);
    verifica("rst_in_ready", 32'(amostra_in_ready), 32'd1);
    verifica("rst_erro_in_ready", 32'(erro_in_ready), 32'd1);
    verifica("rst_erro_out_valid", 32'(erro_out_valid), 32'd0);
    verifica("rst_erro_codigo", 32'(erro_out_codigo), 32'd0);
    verifica("rst_cheio", 32'(cheio), 32'd0);

    // Interleaved fill with the consumer always ready
    saidas.delete();
    amostra_out_ready = 1'b1;
    escreve(1'b0, 16'h0001);
    #1 verifica("t2_sem_saida_um_canal", 32'(amostra_out_valid), 32'd0);
    escreve(1'b1, 16'h0101);
    escreve(1'b0, 16'h0002);
    escreve(1'b1, 16'h0102);
    espera(4);
    verifica("t2_qtd", saidas.size(), 32'd4);
    verifica("t2_s0", 32'(le_saida(0)), {14'd0, 1'b0, 1'b0, 16'h0001});
    verifica("t2_s1", 32'(le_saida(1)), {14'd0, 1'b1, 1'b1, 16'h0101});
    verifica("t2_s2", 32'(le_saida(2)), {14'd0, 1'b0, 1'b0, 16'h0002});
    verifica("t2_s3", 32'(le_saida(3)), {14'd0, 1'b1, 1'b1, 16'h0102});

    // Full channel and backpressure
    aplica_reset();
    saidas.delete();
    for (int i = 0; i < 4; i++) escreve(1'b0, 16'(16'h0010 + i));
    verifica("t3_cheio_ch0", 32'(cheio), 32'b01);
    amostra_in_valid = 1'b1;
    amostra_in_canal = 1'b0;
    amostra_in_dado  = 16'h0014;
    #1 verifica("t3_ready_ch0_cheio", 32'(amostra_in_ready), 32'd0);
    amostra_in_canal = 1'b1;
    amostra_in_dado  = 16'h0020;
    #1 verifica("t3_ready_ch1", 32'(amostra_in_ready), 32'd1);
    ciclo();
    amostra_in_valid = 1'b0;
    verifica("t3_valid_parado", 32'(amostra_out_valid), 32'd1);
    verifica("t3_dado_parado", 32'(amostra_out_dado), 32'h0010);
    ciclo();
    verifica("t3_dado_estavel", {amostra_out_canal, amostra_out_fim, amostra_out_dado}, 32'h0010);
    verifica("t3_cheio_mantido", 32'(cheio), 32'b01);
    amostra_out_ready = 1'b1;
    for (int i = 1; i < 4; i++) escreve(1'b1, 16'(16'h0020 + i));
    espera(8);
    verifica("t3_qtd", saidas.size(), 32'd8);
    for (int i = 0; i < 4; i++) begin
      verifica($sformatf("t3_c0_%0d", i), 32'(le_saida(2*i)),   {14'd0, 1'b0, 1'b0, 16'(16'h0010 + i)});
      verifica($sformatf("t3_c1_%0d", i), 32'(le_saida(2*i+1)), {14'd0, 1'b1, 1'b1, 16'(16'h0020 + i)});
    end

    // Pointer wrap-around over 10 sets
    aplica_reset();
    saidas.delete();
    amostra_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      escreve(1'b0, 16'(16'h0A00 + i));
      escreve(1'b1, 16'(16'h0B00 + i));
    end
    espera(6);
    verifica("t4_qtd", saidas.size(), 32'd20);
    for (int i = 0; i < 10; i++) begin
      verifica($sformatf("t4_c0_%0d", i), 32'(le_saida(2*i)),   {14'd0, 1'b0, 1'b0, 16'(16'h0A00 + i)});
      verifica($sformatf("t4_c1_%0d", i), 32'(le_saida(2*i+1)), {14'd0, 1'b1, 1'b1, 16'(16'h0B00 + i)});
    end

    // Error flush in the middle of a set
    aplica_reset();
    saidas.delete();
    escreve(1'b0, 16'h0031);
    escreve(1'b1, 16'h0051);
    escreve(1'b0, 16'h0032);
    escreve(1'b1, 16'h0052);
    amostra_out_ready = 1'b1;
    ciclo();
    amostra_out_ready = 1'b0;
    verifica("t5_meio_set", {amostra_out_valid, amostra_out_canal, amostra_out_fim, amostra_out_dado}, 32'h7_0051);
    erro_in_valid  = 1'b1;
    erro_in_codigo = 8'h3C;
    #1;
    verifica("t5_out_valid_forcado", 32'(amostra_out_valid), 32'd0);
    verifica("t5_erro_in_ready", 32'(erro_in_ready), 32'd1);
    verifica("t5_in_ready_bloq", 32'(amostra_in_ready), 32'd0);
    ciclo();
    erro_in_valid = 1'b0;
    verifica("t5_erro_out_valid", 32'(erro_out_valid), 32'd1);
    verifica("t5_erro_codigo", 32'(erro_out_codigo), 32'h3C);
    verifica("t5_out_valid_apos", 32'(amostra_out_valid), 32'd0);
    verifica("t5_cheio_apos", 32'(cheio), 32'd0);
    verifica("t5_qtd_antes", saidas.size(), 32'd1);
    saidas.delete();
    amostra_out_ready = 1'b1;
    escreve(1'b1, 16'h0071);
    #1 verifica("t5_sem_saida_so_ch1", 32'(amostra_out_valid), 32'd0);
    escreve(1'b0, 16'h0061);
    espera(4);
    verifica("t5_qtd_novo", saidas.size(), 32'd2);
    verifica("t5_novo_s0", 32'(le_saida(0)), {14'd0, 1'b0, 1'b0, 16'h0061});
    verifica("t5_novo_s1", 32'(le_saida(1)), {14'd0, 1'b1, 1'b1, 16'h0071});

    // Error backpressure (0x3C still pending)
    erro_in_valid  = 1'b1;
    erro_in_codigo = 8'h41;
    #1 verifica("t6_erro_in_ready_bloq", 32'(erro_in_ready), 32'd0);
    ciclo();
    verifica("t6_codigo_mantido", {erro_out_valid, erro_out_codigo}, 32'h13C);
    erro_out_ready = 1'b1;
    #1 verifica("t6_erro_in_ready_lib", 32'(erro_in_ready), 32'd1);
    ciclo();
    erro_in_valid  = 1'b0;
    erro_out_ready = 1'b0;
    verifica("t6_codigo_novo", {erro_out_valid, erro_out_codigo}, 32'h141);
    erro_out_ready = 1'b1;
    ciclo();
    erro_out_ready = 1'b0;
    verifica("t6_erro_limpo", 32'(erro_out_valid), 32'd0);

    // Reset in the middle of a set with an error pending
    amostra_out_ready = 1'b0;
    erro_in_valid  = 1'b1;
    erro_in_codigo = 8'h55;
    ciclo();
    erro_in_valid = 1'b0;
    verifica("t7_erro_pendente", 32'(erro_out_valid), 32'd1);
    escreve(1'b0, 16'h0081);
    escreve(1'b1, 16'h0091);
    amostra_out_ready = 1'b1;
    ciclo();
    amostra_out_ready = 1'b0;
    aplica_reset();
    verifica("t7_erro_out_valid", 32'(erro_out_valid), 32'd0);
    verifica("t7_erro_codigo", 32'(erro_out_codigo), 32'd0);
    verifica("t7_out_valid", 32'(amostra_out_valid), 32'd0);
    verifica("t7_cheio", 32'(cheio), 32'd0);
    saidas.delete();
    amostra_out_ready = 1'b1;
    escreve(1'b1, 16'h00A1);
    #1 verifica("t7_sem_saida_so_ch1", 32'(amostra_out_valid), 32'd0);
    escreve(1'b0, 16'h00A0);
    espera(4);
    verifica("t7_qtd", saidas.size(), 32'd2);
    verifica("t7_s0", 32'(le_saida(0)), {14'd0, 1'b0, 1'b0, 16'h00A0});
    verifica("t7_s1", 32'(le_saida(1)), {14'd0, 1'b1, 1'b1, 16'h00A1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
